if_ctrl: RTL and testbench
==========================

# if_ctrl

Instruction-fetch sequencer that owns the program counter driving the instruction memory. It sits between the ID/EX control logic and the instruction memory. Each cycle it selects the next fetch address from sequential, branch, jump, exception-entry and exception-return sources. It also produces the pipeline flush/valid qualifiers that go with each fetch.

## Interface
- `PC_RESET`, default 32'h0000_3000: first fetch address after reset; this is also the instruction memory base.
- `HANDLER_ADDR`, default 32'h0000_4180: exception handler entry, which is instruction memory word 0x460.
- `IM_WORDS`, default 2048: instruction memory depth in words; used for the range check.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `stall_i`, input, 1: hazard stall; hold the PC.
- `br_taken_i`, input, 1: branch taken; redirect to `br_target_i`.
- `br_target_i`, input, 32: branch target.
- `jmp_i`, input, 1: jump; redirect to `jmp_target_i`.
- `jmp_target_i`, input, 32: jump target.
- `exc_req_i`, input, 1: exception/interrupt entry request.
- `eret_i`, input, 1: exception return.
- `epc_i`, input, 32: return address for `eret_i`.
- `pc_o`, output, 32: current fetch address; drives the instruction memory `pc` input.
- `pc_plus4_o`, output, 32: `pc_o` + 4, with 32-bit wrap.
- `if_valid_o`, output, 1: the instruction fetched this cycle is architecturally live.
- `flush_o`, output, 1: kill the IF/ID contents, asserted for the cycle after a redirect by exception, eret or fault.
- `fetch_fault_o`, output, 1: one-cycle pulse when a fault is detected on `pc_o`.
- `fault_pc_o`, output, 32: value of `pc_o` captured on the last fault.
- `state_o`, output, 2: FSM state; BOOT=0, RUN=1, FLUSH=2.

## Operation
- FSM state BOOT:
  - Entered on reset.
  - `pc_o` is held at `PC_RESET`, `if_valid_o`=0.
  - Unconditionally goes to RUN on the next edge.
- Next-PC priority in RUN and FLUSH, highest first:
  1. fault (only when enabled) goes to `HANDLER_ADDR`
  2. `exc_req_i` goes to `HANDLER_ADDR`
  3. `eret_i` goes to `epc_i`
  4. `stall_i` holds `pc_o`
  5. `br_taken_i` goes to `br_target_i`
  6. `jmp_i` goes to `jmp_target_i`
  7. otherwise `pc_o`+4
- Fault, `exc_req_i` and `eret_i` override `stall_i`. Branch and jump do not.
- A redirect caused by fault, exception or eret moves the FSM to FLUSH. All other cases move it to RUN.
- FLUSH: `flush_o`=1 and `if_valid_o`=0 for exactly that cycle. A further exception or eret in FLUSH re-enters FLUSH. Otherwise the FSM returns to RUN.
- RUN: `if_valid_o`=1 unless `stall_i` is high. A stall marks the re-presented fetch as a bubble.
- Branch and jump redirects do not assert `flush_o`. Delay-slot semantics are kept, and the decoder handles squash.
- Target inputs are used as given; no alignment correction is applied.
- Arithmetic is 32-bit with silent wrap.

## Timing
- Reset values:
  - `pc_o`=`PC_RESET`, `pc_plus4_o`=`PC_RESET`+4
  - `if_valid_o`=0, `flush_o`=0, `fetch_fault_o`=0
  - `fault_pc_o`=0, `state_o`=BOOT
- Reset is asynchronous. Asserting `rst_n` mid-operation forces all reset values immediately, with no clock needed.
- `pc_o`, `state_o`, `fault_pc_o` and `fetch_fault_o` are registered.
- `pc_plus4_o`, `if_valid_o` and `flush_o` are decoded combinationally from registered state only, never from inputs.
- Redirect latency: a request sampled at edge n gives `pc_o`=target after edge n. The instruction memory is combinational, so the instruction is valid in that same cycle.
- Inputs are sampled only at rising edges. Pulses between edges are ignored.

## Configuration
- Macro `IF_FETCH_FAULT_EN`, when defined:
  - A fault is raised if `pc_o`[1:0] != 0, or `pc_o` < `PC_RESET`, or `pc_o` >= `PC_RESET` + 4*`IM_WORDS`.
  - It is evaluated combinationally on registered `pc_o`.
  - `fetch_fault_o` is asserted in the following cycle; `fault_pc_o` captures the faulting address; next PC is `HANDLER_ADDR`; state goes to FLUSH.
  - A fault is not re-raised while `pc_o` is already `HANDLER_ADDR`.
- Macro not defined:
  - No check is made; `fetch_fault_o` is tied to 0 and `fault_pc_o` to 0.
  - Out-of-range addresses alias in the instruction memory index by truncation.

## Structure
- A shared package `if_pkg` holds:
  - the state encoding constants BOOT, RUN and FLUSH
  - the default `PC_RESET` and `HANDLER_ADDR` values
  - the next-PC source-select encoding, shared with hazard/CP0 logic
- One sub-module `if_range_chk`: the combinational fault detector, instantiated only under `IF_FETCH_FAULT_EN`.

## Test plan
- Release reset, no requests:
  - `pc_o`=0x3000 for 2 cycles (BOOT, then RUN); `if_valid_o` goes 0 then 1.
  - After that, 0x3004, 0x3008, …
- At `pc_o`=0x3010, assert `stall_i` for 3 cycles: `pc_o` holds at 0x3010 with `if_valid_o`=0, then resumes at 0x3014.
- Branch and jump:
  - `br_taken_i` with `br_target_i`=0x3100, together with `jmp_i` (target 0x3200): next `pc_o`=0x3100, `flush_o`=0.
  - Then `jmp_i` alone: `pc_o`=0x3200.
- `exc_req_i` together with `stall_i` at `pc_o`=0x3020:
  - Next `pc_o`=0x4180, `flush_o`=1 and `if_valid_o`=0 for one cycle.
  - Then `eret_i` with `epc_i`=0x3024 gives `pc_o`=0x3024, with another FLUSH cycle.
- With `IF_FETCH_FAULT_EN` defined, jump to 0x5000:
  - The following cycle has `fetch_fault_o`=1 and `fault_pc_o`=0x5000.
  - `pc_o` then goes to 0x4180.
  - Repeat with target 0x3002 for the misaligned case.
- Drop `rst_n` between edges while in FLUSH at `pc_o`=0x4180: outputs immediately return to reset values; after release, the sequence restarts at 0x3000 through BOOT.

Source files
------------

// File: rtl/if_pkg.sv
// Shared fetch-sequencer types: FSM states, reset/handler defaults and
// the next-PC source-select encoding used by hazard and CP0 logic.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } if_state_e;

    localparam logic [31:0] PC_RESET_DEF     = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam int          IM_WORDS_DEF     = 2048;

    typedef enum logic [2:0] {
        NPC_SEQ   = 3'd0,
        NPC_HOLD  = 3'd1,
        NPC_BR    = 3'd2,
        NPC_JMP   = 3'd3,
        NPC_EPC   = 3'd4,
        NPC_EXC   = 3'd5,
        NPC_FAULT = 3'd6,
        NPC_BOOT  = 3'd7
    } npc_sel_e;

    // Sources that discard the fetch already in IF/ID.
    function automatic logic sel_flushes(npc_sel_e s);
        return (s == NPC_FAULT) || (s == NPC_EXC) || (s == NPC_EPC);
    endfunction

endpackage

// File: rtl/if_range_chk.sv
// Combinational fetch-address fault detector: misaligned or outside the
// instruction memory window. The handler address itself never faults.
module if_range_chk
    import if_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = PC_RESET_DEF,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter int          IM_WORDS     = IM_WORDS_DEF
) (
    input  logic [31:0] pc,
    output logic        fault
);

    // Window end kept at 33 bits so a window touching 4 GiB cannot wrap.
    localparam logic [32:0] IM_END =
        {1'b0, PC_RESET} + (33'(IM_WORDS) * 33'd4);

    logic misalign;
    logic below;
    logic above;

    assign misalign = (pc[1:0] != 2'b00);
    assign below    = (pc < PC_RESET);
    assign above    = ({1'b0, pc} >= IM_END);
    assign fault    = (misalign || below || above) && (pc != HANDLER_ADDR);

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch sequencer owning the fetch PC.
// Optional fetch-address checking is enabled by defining IF_FETCH_FAULT_EN.
module if_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = PC_RESET_DEF,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter int          IM_WORDS     = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        if_valid_o,
    output logic        flush_o,
    output logic        fetch_fault_o,
    output logic [31:0] fault_pc_o,
    output logic [1:0]  state_o
);

    if_state_e   state;
    if_state_e   state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic        bubble;
    logic        bubble_nx;
    logic        fault;
    npc_sel_e    sel;

`ifdef IF_FETCH_FAULT_EN
    logic fault_raw;

    if_range_chk #(
        .PC_RESET    (PC_RESET),
        .HANDLER_ADDR(HANDLER_ADDR),
        .IM_WORDS    (IM_WORDS)
    ) u_range_chk (
        .pc   (pc),
        .fault(fault_raw)
    );

    assign fault = fault_raw && (state != BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault_o <= 1'b0;
            fault_pc_o    <= 32'h0;
        end else begin
            fetch_fault_o <= fault;
            if (fault) begin
                fault_pc_o <= pc;
            end
        end
    end
`else
    if (IM_WORDS < 1) begin : g_bad_depth
        $error("IM_WORDS must be positive");
    end

    assign fault         = 1'b0;
    assign fetch_fault_o = 1'b0;
    assign fault_pc_o    = 32'h0;
`endif

    // Priority select; fault/exception/eret win over a stall, branch and
    // jump do not.
    always_comb begin
        sel = NPC_SEQ;
        if (state == BOOT) begin
            sel = NPC_BOOT;
        end else if (fault) begin
            sel = NPC_FAULT;
        end else if (exc_req_i) begin
            sel = NPC_EXC;
        end else if (eret_i) begin
            sel = NPC_EPC;
        end else if (stall_i) begin
            sel = NPC_HOLD;
        end else if (br_taken_i) begin
            sel = NPC_BR;
        end else if (jmp_i) begin
            sel = NPC_JMP;
        end
    end

    always_comb begin
        pc_nx = pc + 32'd4;
        case (sel)
            NPC_BOOT:  pc_nx = PC_RESET;
            NPC_FAULT: pc_nx = HANDLER_ADDR;
            NPC_EXC:   pc_nx = HANDLER_ADDR;
            NPC_EPC:   pc_nx = epc_i;
            NPC_HOLD:  pc_nx = pc;
            NPC_BR:    pc_nx = br_target_i;
            NPC_JMP:   pc_nx = jmp_target_i;
            default:   pc_nx = pc + 32'd4;
        endcase
    end

    always_comb begin
        state_nx  = RUN;
        bubble_nx = (sel == NPC_HOLD);
        if (state != BOOT && sel_flushes(sel)) begin
            state_nx = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc     <= PC_RESET;
            bubble <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            bubble <= bubble_nx;
        end
    end

    assign pc_o       = pc;
    assign pc_plus4_o = pc + 32'd4;
    assign if_valid_o = (state == RUN) && !bubble;
    assign flush_o    = (state == FLUSH);
    assign state_o    = state;

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: directed walk through the fetch sequence plus random
// traffic checked every cycle against a behavioural fetch model.
module tb_if_ctrl;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] HANDLER  = 32'h0000_4180;
    localparam int          IM_WORDS = 2048;
`ifdef IF_FETCH_FAULT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_tgt = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_tgt = '0;
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        flush;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    if_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .br_taken_i   (br),
        .br_target_i  (br_tgt),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_tgt),
        .exc_req_i    (exc),
        .eret_i       (eret),
        .epc_i        (epc),
        .pc_o         (pc),
        .pc_plus4_o   (pc_plus4),
        .if_valid_o   (if_valid),
        .flush_o      (flush),
        .fetch_fault_o(fetch_fault),
        .fault_pc_o   (fault_pc),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 boot, 1 run, 2 flush.
    logic [31:0] m_pc;
    int          m_phase;
    bit          m_bubble;
    bit          m_ff;
    logic [31:0] m_fpc;

    function automatic bit bad_addr(logic [31:0] a);
        longint x;
        x = longint'(a);
        if (!FAULT_ON || a == HANDLER) return 1'b0;
        return (a[1:0] != 2'b00) || (x < longint'(PC_RESET)) ||
               (x >= longint'(PC_RESET) + 4 * IM_WORDS);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= PC_RESET; m_phase <= 0; m_bubble <= 0;
            m_ff <= 0; m_fpc <= '0;
        end else if (m_phase == 0) begin
            m_pc <= PC_RESET; m_phase <= 1; m_bubble <= 0; m_ff <= 0;
        end else if (bad_addr(m_pc)) begin
            m_pc <= HANDLER; m_phase <= 2; m_bubble <= 0;
            m_ff <= 1; m_fpc <= m_pc;
        end else begin
            m_ff <= 0;
            m_bubble <= 0;
            m_phase <= 1;
            if (exc) begin
                m_pc <= HANDLER; m_phase <= 2;
            end else if (eret) begin
                m_pc <= epc; m_phase <= 2;
            end else if (stall) begin
                m_bubble <= 1;
            end else if (br) begin
                m_pc <= br_tgt;
            end else if (jmp) begin
                m_pc <= jmp_tgt;
            end else begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("if_valid", 32'(if_valid), 32'(m_phase == 1 && !m_bubble));
            check("flush", 32'(flush), 32'(m_phase == 2));
            check("fetch_fault", 32'(fetch_fault), 32'(m_ff));
            check("fault_pc", fault_pc, m_fpc);
            check("state", 32'(state), 32'(m_phase));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_tgt();
        if ($urandom_range(0, 9) == 0) return $urandom();
        return PC_RESET + 32'(4 * $urandom_range(0, IM_WORDS - 1));
    endfunction

    task automatic chk_reset_vals(string tag);
        check({tag, "_pc"}, pc, 32'h3000);
        check({tag, "_p4"}, pc_plus4, 32'h3004);
        check({tag, "_valid"}, 32'(if_valid), 0);
        check({tag, "_flush"}, 32'(flush), 0);
        check({tag, "_ff"}, 32'(fetch_fault), 0);
        check({tag, "_fpc"}, fault_pc, 0);
        check({tag, "_state"}, 32'(state), 0);
    endtask

    initial begin
        cmp_en = 1'b1;
        repeat (2) cyc();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        cyc();
        check("boot_run_pc", pc, 32'h3000);
        check("boot_run_valid", 32'(if_valid), 1);
        check("boot_run_state", 32'(state), 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("seq_pc", pc, 32'h3000 + 32'(4 * i));
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_pc", pc, 32'h3010);
            check("stall_valid", 32'(if_valid), 0);
        end
        stall = 1'b0;
        cyc();
        check("resume_pc", pc, 32'h3014);
        check("resume_valid", 32'(if_valid), 1);
        br = 1'b1; br_tgt = 32'h3100; jmp = 1'b1; jmp_tgt = 32'h3200;
        cyc();
        check("br_pc", pc, 32'h3100);
        check("br_flush", 32'(flush), 0);
        br = 1'b0;
        cyc();
        check("jmp_pc", pc, 32'h3200);
        jmp_tgt = 32'h3020;
        cyc();
        check("jmp2_pc", pc, 32'h3020);
        jmp = 1'b0; exc = 1'b1; stall = 1'b1;
        cyc();
        check("exc_pc", pc, 32'h4180);
        check("exc_flush", 32'(flush), 1);
        check("exc_valid", 32'(if_valid), 0);
        exc = 1'b0; stall = 1'b0; eret = 1'b1; epc = 32'h3024;
        cyc();
        check("eret_pc", pc, 32'h3024);
        check("eret_flush", 32'(flush), 1);
        eret = 1'b0;
        cyc();
        check("post_eret_pc", pc, 32'h3028);
        check("post_eret_flush", 32'(flush), 0);
        check("post_eret_valid", 32'(if_valid), 1);
        jmp = 1'b1; jmp_tgt = 32'h5000;
        cyc();
        jmp = 1'b0;
        check("oor_pc", pc, 32'h5000);
        check("oor_ff0", 32'(fetch_fault), 0);
        cyc();
        if (FAULT_ON) begin
            check("oor_ff", 32'(fetch_fault), 1);
            check("oor_fpc", fault_pc, 32'h5000);
            check("oor_hpc", pc, 32'h4180);
        end else begin
            check("alias_pc", pc, 32'h5004);
            check("alias_ff", 32'(fetch_fault), 0);
        end
        jmp = 1'b1; jmp_tgt = 32'h3002;
        cyc();
        jmp = 1'b0;
        cyc();
        if (FAULT_ON) begin
            check("mis_ff", 32'(fetch_fault), 1);
            check("mis_fpc", fault_pc, 32'h3002);
            check("mis_hpc", pc, 32'h4180);
        end else begin
            check("mis_alias_pc", pc, 32'h3006);
        end
        exc = 1'b1;
        cyc();
        exc = 1'b0;
        check("pre_rst_pc", pc, 32'h4180);
        check("pre_rst_state", 32'(state), 2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        cyc();
        rst_n = 1'b1;
        cyc();
        check("restart_pc", pc, 32'h3000);
        check("restart_state", 32'(state), 1);
        cyc();
        check("restart_seq", pc, 32'h3004);

        for (int i = 0; i < 4000; i++) begin
            stall   = ($urandom_range(0, 4) == 0);
            br      = ($urandom_range(0, 6) == 0);
            jmp     = ($urandom_range(0, 6) == 0);
            exc     = ($urandom_range(0, 24) == 0);
            eret    = ($urandom_range(0, 24) == 0);
            br_tgt  = rnd_tgt();
            jmp_tgt = rnd_tgt();
            epc     = rnd_tgt();
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
